usb_tx_buf: RTL and testbench

Packet staging buffer sitting directly upstream of `usb_tx_pkt`. Accepts payload bytes from the device-side logic into a circular byte buffer, then on a command launches one packet: it drives `pkt_start`, `pkt_pid` and `pkt_len`, and streams bytes out through the `pkt_data` / `pkt_data_ack` handshake until `pkt_done`. Zero-length packets (handshakes such as ACK/NAK, or empty DATAx) use the same path with `pkt_len = 0`.

---
 rtl/usb_tx_buf.sv | 179 +++++++++++++++++
 tb/tb_usb_tx_buf.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_buf.sv
// Circular byte buffer that stages one USB packet for usb_tx_pkt; pkt_start 2 cycles after cmd_valid, one byte per pkt_data_ack.
// Writes while full are dropped (wr_ovf). Define USB_TX_BUF_RETRY_EN for HOLD with commit/retry replay.
module usb_tx_buf #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    output logic       wr_full,
    output logic       wr_ovf,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_pid,
    output logic       cmd_ready,
    output logic       busy,
    output logic       tx_done,
`ifdef USB_TX_BUF_RETRY_EN
    input  logic       cmd_retry,
    input  logic       cmd_commit,
`endif
    output logic       pkt_start,
    output logic [3:0] pkt_pid,
    output logic [9:0] pkt_len,
    output logic [7:0] pkt_data,
    input  logic       pkt_done,
    input  logic       pkt_data_ack
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0]         CNT_ONE = 1;
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_SEND
`ifdef USB_TX_BUF_RETRY_EN
        , S_HOLD
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] base_q, base_d;
    logic [CW-1:0]         count_q, count_d;
    logic [9:0]            rem_q, rem_d;
    logic [3:0]            pkt_pid_q, pkt_pid_d;
    logic [9:0]            pkt_len_q, pkt_len_d;
    logic [7:0]            pkt_data_q, pkt_data_d;
    logic                  pkt_start_q, pkt_start_d;
    logic                  tx_done_q, tx_done_d;
    logic                  wr_ovf_q, wr_ovf_d;

    logic                  wr_acc;
    logic                  adv;
    logic [10:0]           cnt_ext;
    logic [9:0]            len_sat;

    assign wr_full   = (count_q == CNT_FULL);
    assign wr_ovf    = wr_ovf_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign tx_done   = tx_done_q;
    assign pkt_start = pkt_start_q;
    assign pkt_pid   = pkt_pid_q;
    assign pkt_len   = pkt_len_q;
    assign pkt_data  = pkt_data_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        base_d      = base_q;
        count_d     = count_q;
        rem_d       = rem_q;
        pkt_pid_d   = pkt_pid_q;
        pkt_len_d   = pkt_len_q;
        tx_done_d   = 1'b0;
        pkt_start_d = (state_q == S_START);

        wr_acc   = wr_en && !wr_full;
        wr_ovf_d = wr_en && wr_full;
        adv      = (state_q == S_SEND) && pkt_data_ack && (rem_q != 10'd0);

        // A full 1024-byte buffer cannot be described in 10 bits; clamp to 1023.
        cnt_ext = 11'(count_q);
        len_sat = (cnt_ext > 11'd1023) ? 10'h3FF : cnt_ext[9:0];

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    pkt_pid_d = cmd_pid;
                    pkt_len_d = len_sat;
                    rem_d     = len_sat;
                    base_d    = rd_ptr_q;
                    state_d   = S_START;
                end
            end
            S_START: state_d = S_SEND;
            S_SEND: begin
                if (adv) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    rem_d    = rem_q - 10'd1;
`ifndef USB_TX_BUF_RETRY_EN
                    count_d  = count_d - CNT_ONE;
`endif
                end
                if (pkt_done) begin
                    tx_done_d = 1'b1;
`ifdef USB_TX_BUF_RETRY_EN
                    state_d   = S_HOLD;
`else
                    state_d   = S_IDLE;
`endif
                end
            end
`ifdef USB_TX_BUF_RETRY_EN
            S_HOLD: begin
                // Bytes stay owned by the packet until commit so a retry can replay them.
                if (cmd_commit) begin
                    count_d = count_d - CW'(pkt_len_q);
                    state_d = S_IDLE;
                end else if (cmd_retry) begin
                    rd_ptr_d = base_q;
                    rem_d    = pkt_len_q;
                    state_d  = S_START;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        pkt_data_d = mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            base_q      <= '0;
            count_q     <= '0;
            rem_q       <= '0;
            pkt_pid_q   <= '0;
            pkt_len_q   <= '0;
            pkt_data_q  <= '0;
            pkt_start_q <= 1'b0;
            tx_done_q   <= 1'b0;
            wr_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            base_q      <= base_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            pkt_pid_q   <= pkt_pid_d;
            pkt_len_q   <= pkt_len_d;
            pkt_data_q  <= pkt_data_d;
            pkt_start_q <= pkt_start_d;
            tx_done_q   <= tx_done_d;
            wr_ovf_q    <= wr_ovf_d;
        end
    end

endmodule

// File: tb/tb_usb_tx_buf.sv
// Directed bench for usb_tx_buf (DEPTH_LOG2 = 6); retry scenario built only with USB_TX_BUF_RETRY_EN.
module tb_usb_tx_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       wr_full, wr_ovf;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_pid = '0;
    logic       cmd_ready, busy, tx_done;
`ifdef USB_TX_BUF_RETRY_EN
    logic       cmd_retry = 1'b0;
    logic       cmd_commit = 1'b0;
`endif
    logic       pkt_start;
    logic [3:0] pkt_pid;
    logic [9:0] pkt_len;
    logic [7:0] pkt_data;
    logic       pkt_done = 1'b0;
    logic       pkt_data_ack = 1'b0;

    int errs = 0;
    int checks = 0;

    usb_tx_buf #(.DEPTH_LOG2(6)) dut (
        .clk(clk), .rst(rst),
        .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full), .wr_ovf(wr_ovf),
        .cmd_valid(cmd_valid), .cmd_pid(cmd_pid), .cmd_ready(cmd_ready),
        .busy(busy), .tx_done(tx_done),
`ifdef USB_TX_BUF_RETRY_EN
        .cmd_retry(cmd_retry), .cmd_commit(cmd_commit),
`endif
        .pkt_start(pkt_start), .pkt_pid(pkt_pid), .pkt_len(pkt_len),
        .pkt_data(pkt_data), .pkt_done(pkt_done), .pkt_data_ack(pkt_data_ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en = 1'b1;
        wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // After this returns the DUT is in the pkt_start cycle.
    task automatic launch(input logic [3:0] pid);
        cmd_valid = 1'b1;
        cmd_pid = pid;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    task automatic finish_pkt;
        pkt_done = 1'b1;
        tick();
        pkt_done = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if ({pkt_start, tx_done, wr_ovf, busy, wr_full} !== 5'b0) begin errs++; $display("FAIL reset_flags got %b want 00000", {pkt_start, tx_done, wr_ovf, busy, wr_full}); end
        checks++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++; if ({pkt_pid, pkt_len, pkt_data} !== 22'd0) begin errs++; $display("FAIL reset_pkt got pid=%h len=%0d data=%h want 0", pkt_pid, pkt_len, pkt_data); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        for (int i = 0; i < 3; i++) write_byte(exp[i]);
        launch(4'h3);
        checks++; if (pkt_start !== 1'b1) begin errs++; $display("FAIL basic_start got %b want 1", pkt_start); end
        checks++; if (pkt_len !== 10'd3) begin errs++; $display("FAIL basic_len got %0d want 3", pkt_len); end
        checks++; if (pkt_pid !== 4'h3) begin errs++; $display("FAIL basic_pid got %h want 3", pkt_pid); end
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errs++; $display("FAIL basic_busy got busy=%b rdy=%b want 1/0", busy, cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (pkt_data !== exp[i]) begin errs++; $display("FAIL basic_data%0d got %h want %h", i, pkt_data, exp[i]); end
            pkt_data_ack = 1'b1;
            tick();
            if (i == 0) begin
                checks++; if (pkt_start !== 1'b0) begin errs++; $display("FAIL basic_start_width got %b want 0", pkt_start); end
            end
        end
        pkt_data_ack = 1'b0;
        finish_pkt();
        checks++; if (tx_done !== 1'b1 || cmd_ready !== 1'b1) begin errs++; $display("FAIL basic_done got tx_done=%b rdy=%b want 1/1", tx_done, cmd_ready); end
        tick();
        checks++; if (tx_done !== 1'b0) begin errs++; $display("FAIL basic_done_pulse got %b want 0", tx_done); end
        checks++; if (int'(dut.count_q) != 0) begin errs++; $display("FAIL basic_count got %0d want 0", dut.count_q); end
    endtask

    task automatic test_zero_len;
        launch(4'h2);
        checks++; if (pkt_len !== 10'd0 || pkt_pid !== 4'h2) begin errs++; $display("FAIL zlp_len got len=%0d pid=%h want 0/2", pkt_len, pkt_pid); end
        pkt_data_ack = 1'b1;
        tick();
        tick();
        pkt_data_ack = 1'b0;
        checks++; if (int'(dut.rd_ptr_q) != 3) begin errs++; $display("FAIL zlp_rd_ptr got %0d want 3", dut.rd_ptr_q); end
        checks++; if (int'(dut.count_q) != 0) begin errs++; $display("FAIL zlp_count got %0d want 0", dut.count_q); end
        finish_pkt();
        checks++; if (tx_done !== 1'b1) begin errs++; $display("FAIL zlp_done got %b want 1", tx_done); end
    endtask

    task automatic test_full_wrap;
        logic [7:0] exp [64];
        for (int i = 0; i < 64; i++) exp[i] = 8'(i * 37 + 1);
        for (int i = 0; i < 64; i++) begin
            write_byte(exp[i]);
            if (i == 62) begin
                checks++; if (wr_full !== 1'b0) begin errs++; $display("FAIL full_early got %b want 0", wr_full); end
            end
        end
        checks++; if (wr_full !== 1'b1 || wr_ovf !== 1'b0) begin errs++; $display("FAIL full_set got full=%b ovf=%b want 1/0", wr_full, wr_ovf); end
        write_byte(8'hEE);
        checks++; if (wr_ovf !== 1'b1) begin errs++; $display("FAIL ovf_pulse got %b want 1", wr_ovf); end
        tick();
        checks++; if (wr_ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", wr_ovf); end
        launch(4'hB);
        checks++; if (pkt_len !== 10'd64) begin errs++; $display("FAIL full_len got %0d want 64", pkt_len); end
        for (int i = 0; i < 64; i++) begin
            checks++; if (pkt_data !== exp[i]) begin errs++; $display("FAIL wrap_data%0d got %h want %h", i, pkt_data, exp[i]); end
            pkt_data_ack = 1'b1;
            tick();
        end
        pkt_data_ack = 1'b0;
        finish_pkt();
        checks++; if (wr_full !== 1'b0 || int'(dut.count_q) != 0) begin errs++; $display("FAIL wrap_drain got full=%b count=%0d want 0/0", wr_full, dut.count_q); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a [4];
        logic [7:0] b [2];
        a[0] = 8'hA0; a[1] = 8'hA1; a[2] = 8'hA2; a[3] = 8'hA3;
        b[0] = 8'hB0; b[1] = 8'hB1;
        for (int i = 0; i < 4; i++) write_byte(a[i]);
        launch(4'hB);
        for (int i = 0; i < 4; i++) begin
            checks++; if (pkt_data !== a[i]) begin errs++; $display("FAIL mid_data%0d got %h want %h", i, pkt_data, a[i]); end
            pkt_data_ack = 1'b1;
            wr_en = (i == 1 || i == 2);
            wr_data = (i == 1) ? b[0] : b[1];
            cmd_valid = (i == 1 || i == 2);
            cmd_pid = 4'h9;
            tick();
        end
        pkt_data_ack = 1'b0;
        wr_en = 1'b0;
        cmd_valid = 1'b0;
        checks++; if (pkt_len !== 10'd4 || pkt_pid !== 4'hB || busy !== 1'b1) begin errs++; $display("FAIL mid_cmd_ignored got len=%0d pid=%h busy=%b want 4/b/1", pkt_len, pkt_pid, busy); end
        finish_pkt();
        checks++; if (int'(dut.count_q) != 2) begin errs++; $display("FAIL mid_count got %0d want 2", dut.count_q); end
        launch(4'hC);
        checks++; if (pkt_len !== 10'd2 || pkt_pid !== 4'hC) begin errs++; $display("FAIL next_len got len=%0d pid=%h want 2/c", pkt_len, pkt_pid); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (pkt_data !== b[i]) begin errs++; $display("FAIL next_data%0d got %h want %h", i, pkt_data, b[i]); end
            pkt_data_ack = 1'b1;
            tick();
        end
        pkt_data_ack = 1'b0;
        finish_pkt();
        checks++; if (int'(dut.count_q) != 0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL next_drain got count=%0d rdy=%b want 0/1", dut.count_q, cmd_ready); end
    endtask

`ifdef USB_TX_BUF_RETRY_EN
    task automatic test_retry;
        logic [7:0] exp [5];
        for (int i = 0; i < 5; i++) exp[i] = 8'(8'h50 + i);
        for (int i = 0; i < 5; i++) write_byte(exp[i]);
        launch(4'h7);
        for (int pass = 0; pass < 2; pass++) begin
            checks++; if (pkt_start !== 1'b1 || pkt_len !== 10'd5 || pkt_pid !== 4'h7) begin errs++; $display("FAIL retry_hdr%0d got start=%b len=%0d pid=%h want 1/5/7", pass, pkt_start, pkt_len, pkt_pid); end
            for (int i = 0; i < 5; i++) begin
                checks++; if (pkt_data !== exp[i]) begin errs++; $display("FAIL retry_data%0d_%0d got %h want %h", pass, i, pkt_data, exp[i]); end
                pkt_data_ack = 1'b1;
                tick();
            end
            pkt_data_ack = 1'b0;
            finish_pkt();
            checks++; if (busy !== 1'b1 || tx_done !== 1'b1 || int'(dut.count_q) != 5) begin errs++; $display("FAIL hold%0d got busy=%b done=%b count=%0d want 1/1/5", pass, busy, tx_done, dut.count_q); end
            if (pass == 0) begin
                cmd_retry = 1'b1;
                tick();
                cmd_retry = 1'b0;
                tick();
            end
        end
        cmd_retry = 1'b1;
        cmd_commit = 1'b1;
        tick();
        cmd_retry = 1'b0;
        cmd_commit = 1'b0;
        checks++; if (int'(dut.count_q) != 0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL commit got count=%0d rdy=%b want 0/1", dut.count_q, cmd_ready); end
        tick();
        checks++; if (pkt_start !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL commit_wins got start=%b busy=%b want 0/0", pkt_start, busy); end
    endtask
`endif

    task automatic test_async_reset;
        for (int i = 0; i < 8; i++) write_byte(8'(8'hC0 + i));
        launch(4'h5);
        pkt_data_ack = 1'b1;
        tick();
        tick();
        pkt_data_ack = 1'b0;
        checks++; if (pkt_data !== 8'hC2) begin errs++; $display("FAIL rst_pre_data got %h want c2", pkt_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({pkt_start, tx_done, wr_ovf, busy, wr_full} !== 5'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL arst_flags got %b rdy=%b want 00000/1", {pkt_start, tx_done, wr_ovf, busy, wr_full}, cmd_ready); end
        checks++; if ({pkt_pid, pkt_len, pkt_data} !== 22'd0) begin errs++; $display("FAIL arst_pkt got pid=%h len=%0d data=%h want 0", pkt_pid, pkt_len, pkt_data); end
        checks++; if (int'(dut.count_q) != 0 || int'(dut.rd_ptr_q) != 0 || int'(dut.wr_ptr_q) != 0) begin errs++; $display("FAIL arst_ptrs got count=%0d rd=%0d wr=%0d want 0", dut.count_q, dut.rd_ptr_q, dut.wr_ptr_q); end
        @(negedge clk);
        rst = 1'b0;
        launch(4'h2);
        checks++; if (pkt_len !== 10'd0) begin errs++; $display("FAIL arst_discard got len=%0d want 0", pkt_len); end
        finish_pkt();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_full_wrap();
        test_back_to_back();
`ifdef USB_TX_BUF_RETRY_EN
        test_retry();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
